// File: rtl/adder_pipe_seg.sv
// ---------------------------------------------------------------------------
// adder_pipe_seg
//
// Segmented, carry-pipelined WIDTH-bit adder/subtractor. The word is split
// into SEGS slices of SW = WIDTH/SEGS bits. Stage k adds slice k and passes
// its carry to stage k+1 on the next enabled clock. Operand slices that have
// not been consumed yet travel down the pipe with the beat (skew), and result
// slices that are already done travel along with them (de-skew), so the whole
// result word leaves the last stage aligned.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operand beat valid
//   in_ready   block accepts a beat this cycle (= pipeline enable)
//   op0, op1   operands A and B (unsigned or two's complement)
//   cin        carry-in (add) / borrow-in (subtract)
//   sub        0 = A + B + cin, 1 = A - B - cin
//   out_valid  result beat valid
//   out_ready  downstream accepts the result
//   sum        result word
//   cout       carry-out (add) / borrow-out (subtract)
//   ovf        signed two's-complement overflow
// ---------------------------------------------------------------------------
module adder_pipe_seg #(
    parameter int WIDTH = 32,
    parameter int SEGS  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op0,
    input  logic [WIDTH-1:0] op1,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int SW   = WIDTH / SEGS;
    localparam int LAST = SEGS - 1;

    // Elaboration-time parameter checks.
    if ((SEGS < 1) || (SEGS > WIDTH)) begin : g_bad_segs
        $error("adder_pipe_seg: SEGS must lie in 1..WIDTH");
    end
    if ((WIDTH % SEGS) != 0) begin : g_bad_width
        $error("adder_pipe_seg: WIDTH must be a multiple of SEGS");
    end

    // One slice of the ripple: {carry, sum} with SW+1-bit arithmetic.
    function automatic logic [SW:0] seg_add(
        input logic [SW-1:0] x,
        input logic [SW-1:0] y,
        input logic          ci
    );
        return {1'b0, x} + {1'b0, y} + {{SW{1'b0}}, ci};
    endfunction

    // Pipeline state, index = stage that produced it.
    logic [SEGS-1:0]  vld_p;
    logic [SEGS-1:0]  sub_p;
    logic [SEGS-1:0]  cry_p;
    logic [WIDTH-1:0] a_p [SEGS];
    logic [WIDTH-1:0] b_p [SEGS];
    logic [WIDTH-1:0] s_p [SEGS];

    // Inputs seen by each stage.
    logic [SEGS-1:0]  vld_src;
    logic [SEGS-1:0]  sub_src;
    logic [SEGS-1:0]  cry_src;
    logic [WIDTH-1:0] a_src [SEGS];
    logic [WIDTH-1:0] b_src [SEGS];
    logic [WIDTH-1:0] s_src [SEGS];

    // Per-stage results.
    logic [SW:0]      seg_res [SEGS];
    logic [SEGS-1:0]  cry_nxt;
    logic [WIDTH-1:0] s_nxt [SEGS];

    logic en;

    // The whole pipe moves together; a full output slot that nobody takes
    // freezes every stage, bubbles included.
    assign en       = out_ready | ~vld_p[LAST];
    assign in_ready = en;

    // ---- stage 0 input: operand conditioning ----
    // Subtract is A + ~B + ~borrow, so a borrow-in of 1 becomes carry-in 0.
    always_comb begin
        vld_src[0] = in_valid;
        sub_src[0] = sub;
        cry_src[0] = sub ? ~cin : cin;
        a_src[0]   = op0;
        b_src[0]   = sub ? ~op1 : op1;
        s_src[0]   = '0;
        for (int k = 1; k < SEGS; k++) begin
            vld_src[k] = vld_p[k-1];
            sub_src[k] = sub_p[k-1];
            cry_src[k] = cry_p[k-1];
            a_src[k]   = a_p[k-1];
            b_src[k]   = b_p[k-1];
            s_src[k]   = s_p[k-1];
        end
    end

    // ---- stages 0..SEGS-1: slice k add, other slices pass through ----
    always_comb begin
        for (int k = 0; k < SEGS; k++) begin
            seg_res[k]              = seg_add(a_src[k][k*SW +: SW],
                                              b_src[k][k*SW +: SW],
                                              cry_src[k]);
            cry_nxt[k]              = seg_res[k][SW];
            s_nxt[k]                = s_src[k];
            s_nxt[k][k*SW +: SW]    = seg_res[k][SW-1:0];
        end
    end

    // ---- pipeline registers ----
    // Data captured on every enabled cycle, bubbles too, so a bubble slot
    // holds whatever the inputs were: deterministic, never observed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p <= '0;
            sub_p <= '0;
            cry_p <= '0;
            for (int k = 0; k < SEGS; k++) begin
                a_p[k] <= '0;
                b_p[k] <= '0;
                s_p[k] <= '0;
            end
        end else if (en) begin
            vld_p <= vld_src;
            sub_p <= sub_src;
            cry_p <= cry_nxt;
            for (int k = 0; k < SEGS; k++) begin
                a_p[k] <= a_src[k];
                b_p[k] <= b_src[k];
                s_p[k] <= s_nxt[k];
            end
        end
    end

    // ---- output stage ----
    // b_p holds the conditioned operand, so one overflow rule covers add and
    // subtract. Flipping the final carry with sub turns it into a borrow.
    assign out_valid = vld_p[LAST];
    assign sum       = s_p[LAST];
    assign cout      = cry_p[LAST] ^ sub_p[LAST];
    assign ovf       = (a_p[LAST][WIDTH-1] == b_p[LAST][WIDTH-1]) &
                       (s_p[LAST][WIDTH-1] != a_p[LAST][WIDTH-1]);

endmodule

// File: tb/tb_adder_pipe_seg.sv
module tb_adder_pipe_seg;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [W-1:0] op0, op1;
    logic         cin, sub, out_ready;

    logic         iv4, ir4, ov4, co4, of4;
    logic [W-1:0] s4;
    logic         iv1, ir1, ov1, co1, of1;
    logic [W-1:0] s1;
    logic         iv8, ir8, ov8, co8, of8;
    logic [W-1:0] s8;

    always #5 clk = ~clk;

    adder_pipe_seg #(.WIDTH(32), .SEGS(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir4),
        .op0(op0), .op1(op1), .cin(cin), .sub(sub),
        .out_valid(ov4), .out_ready(out_ready), .sum(s4), .cout(co4), .ovf(of4)
    );
    adder_pipe_seg #(.WIDTH(32), .SEGS(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1),
        .op0(op0), .op1(op1), .cin(cin), .sub(sub),
        .out_valid(ov1), .out_ready(out_ready), .sum(s1), .cout(co1), .ovf(of1)
    );
    adder_pipe_seg #(.WIDTH(32), .SEGS(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8),
        .op0(op0), .op1(op1), .cin(cin), .sub(sub),
        .out_valid(ov8), .out_ready(out_ready), .sum(s8), .cout(co8), .ovf(of8)
    );

    int total = 0;
    int bad   = 0;

    // Hand-computed directed beats: operands, controls and expected results.
    logic [W-1:0] t_a [8] = '{32'h1234_5678, 32'h0000_0005, 32'h7FFF_FFFF, 32'h8000_0000,
                              32'hFFFF_FFFF, 32'h0000_0007, 32'h0000_FFFF, 32'h0000_0000};
    logic [W-1:0] t_b [8] = '{32'h1111_1111, 32'h0000_0007, 32'h0000_0001, 32'h0000_0001,
                              32'hFFFF_FFFF, 32'h0000_0005, 32'h0000_0001, 32'h0000_0000};
    logic         t_ci [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    logic         t_sb [8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [W-1:0] t_s [8] = '{32'h2345_6789, 32'hFFFF_FFFE, 32'h8000_0000, 32'h7FFF_FFFF,
                              32'hFFFF_FFFF, 32'h0000_0001, 32'h0001_0000, 32'hFFFF_FFFF};
    logic         t_co [8] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    logic         t_ov [8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

    task automatic chk_w(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic chk_b(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int i);
        op0 = t_a[i];
        op1 = t_b[i];
        cin = t_ci[i];
        sub = t_sb[i];
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int sent, got, stall;
        logic [W-1:0] h_s;
        logic h_c, h_o;

        rst_n = 1'b0;
        iv4 = 1'b0; iv1 = 1'b0; iv8 = 1'b0;
        op0 = '0; op1 = '0; cin = 1'b0; sub = 1'b0;
        out_ready = 1'b1;
        tick();
        tick();

        // Reset state
        chk_b("rst_out_valid", ov4, 1'b0);
        chk_w("rst_sum", s4, 32'h0);
        chk_b("rst_cout", co4, 1'b0);
        chk_b("rst_ovf", of4, 1'b0);
        chk_b("rst_in_ready", ir4, 1'b1);

        rst_n = 1'b1;
        tick();

        // Carry ripple through every slice, on SEGS = 4, 1 and 8
        op0 = 32'hFFFF_FFFF; op1 = 32'h0000_0001; cin = 1'b0; sub = 1'b0;
        iv4 = 1'b1; iv1 = 1'b1; iv8 = 1'b1;
        tick();
        iv4 = 1'b0; iv1 = 1'b0; iv8 = 1'b0;
        for (int n = 1; n <= 9; n++) begin
            chk_b($sformatf("rip_s4_valid_c%0d", n), ov4, n == 4);
            chk_b($sformatf("rip_s1_valid_c%0d", n), ov1, n == 1);
            chk_b($sformatf("rip_s8_valid_c%0d", n), ov8, n == 8);
            if (n == 4) begin
                chk_w("rip_s4_sum", s4, 32'h0);
                chk_b("rip_s4_cout", co4, 1'b1);
                chk_b("rip_s4_ovf", of4, 1'b0);
            end
            if (n == 1) begin
                chk_w("rip_s1_sum", s1, 32'h0);
                chk_b("rip_s1_cout", co1, 1'b1);
                chk_b("rip_s1_ovf", of1, 1'b0);
            end
            if (n == 8) begin
                chk_w("rip_s8_sum", s8, 32'h0);
                chk_b("rip_s8_cout", co8, 1'b1);
                chk_b("rip_s8_ovf", of8, 1'b0);
            end
            tick();
        end

        // Streaming: 8 back-to-back alternating add/sub beats
        for (int n = 0; n < 12; n++) begin
            if (n < 8) begin
                drive(n);
                iv4 = 1'b1;
            end else begin
                iv4 = 1'b0;
            end
            #1;
            chk_b($sformatf("str_in_ready_c%0d", n), ir4, 1'b1);
            tick();
            if (n >= 3 && n <= 10) begin
                chk_b($sformatf("str_valid_b%0d", n - 3), ov4, 1'b1);
                chk_w($sformatf("str_sum_b%0d", n - 3), s4, t_s[n-3]);
                chk_b($sformatf("str_cout_b%0d", n - 3), co4, t_co[n-3]);
                chk_b($sformatf("str_ovf_b%0d", n - 3), of4, t_ov[n-3]);
            end else begin
                chk_b($sformatf("str_idle_c%0d", n), ov4, 1'b0);
            end
        end

        // Backpressure: 6 beats, out_ready dropped 3 cycles at first result
        sent = 0; got = 0; stall = 0;
        h_s = '0; h_c = 1'b0; h_o = 1'b0;
        for (int cyc = 0; cyc < 40 && got < 6; cyc++) begin
            if (sent < 6) begin
                drive(sent);
                iv4 = 1'b1;
            end else begin
                iv4 = 1'b0;
            end
            if (ov4 && stall < 3) begin
                if (stall == 0) begin
                    h_s = s4; h_c = co4; h_o = of4;
                end else begin
                    chk_w($sformatf("bp_hold_sum_%0d", stall), s4, h_s);
                    chk_b($sformatf("bp_hold_cout_%0d", stall), co4, h_c);
                    chk_b($sformatf("bp_hold_ovf_%0d", stall), of4, h_o);
                end
                out_ready = 1'b0;
                stall++;
                #1;
                chk_b($sformatf("bp_in_ready_low_%0d", stall), ir4, 1'b0);
            end else begin
                out_ready = 1'b1;
                #1;
                chk_b($sformatf("bp_in_ready_high_c%0d", cyc), ir4, 1'b1);
                if (ov4) begin
                    chk_w($sformatf("bp_sum_b%0d", got), s4, t_s[got]);
                    chk_b($sformatf("bp_cout_b%0d", got), co4, t_co[got]);
                    chk_b($sformatf("bp_ovf_b%0d", got), of4, t_ov[got]);
                    got++;
                end
            end
            if (iv4 && ir4) sent++;
            tick();
        end
        iv4 = 1'b0;
        out_ready = 1'b1;
        chk_w("bp_beats_sent", sent, 32'd6);
        chk_w("bp_beats_received", got, 32'd6);
        chk_w("bp_stall_cycles", stall, 32'd3);
        chk_b("bp_drained", ov4, 1'b0);

        // Reset mid-flight: one beat at the output, three more in the pipe
        for (int n = 4; n < 8; n++) begin
            drive(n);
            iv4 = 1'b1;
            tick();
        end
        iv4 = 1'b0;
        chk_b("mid_pre_valid", ov4, 1'b1);
        chk_w("mid_pre_sum", s4, 32'hFFFF_FFFF);
        rst_n = 1'b0;
        #1;
        chk_b("mid_rst_valid", ov4, 1'b0);
        chk_w("mid_rst_sum", s4, 32'h0);
        chk_b("mid_rst_cout", co4, 1'b0);
        chk_b("mid_rst_ovf", of4, 1'b0);
        chk_b("mid_rst_in_ready", ir4, 1'b1);
        tick();
        tick();
        rst_n = 1'b1;
        for (int n = 0; n < 5; n++) begin
            tick();
            chk_b($sformatf("mid_no_ghost_c%0d", n), ov4, 1'b0);
        end
        drive(0);
        iv4 = 1'b1;
        tick();
        iv4 = 1'b0;
        for (int n = 1; n <= 5; n++) begin
            chk_b($sformatf("mid_new_valid_c%0d", n), ov4, n == 4);
            if (n == 4) begin
                chk_w("mid_new_sum", s4, t_s[0]);
                chk_b("mid_new_cout", co4, t_co[0]);
            end
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
